start_screen_sequencer: RTL and testbench

//  Sequences the start-screen palette. Per pixel, it picks the 4-bit colour index that

---
 rtl/start_screen_sequencer.sv | 148 ++++++++++++++
 tb/tb_start_screen_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/start_screen_sequencer.sv
// Start-screen palette sequencer.
// Chooses the palette index for each pixel of the title screen. It blinks the
// "press start" prompt in attract mode and runs a short highlight flash after
// start is pressed. When the sequence completes, it hands control to the game
// FSM with a one-cycle start_game pulse.
module start_screen_sequencer #(
    parameter int         BLINK_FRAMES  = 30,
    parameter int         FLASH_FRAMES  = 4,
    parameter int         FLASH_TOGGLES = 6,
    parameter logic [3:0] IDX_BG        = 4'h0,
    parameter logic [3:0] IDX_HILITE    = 4'h1,
    parameter logic [3:0] IDX_TEXT      = 4'h2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       vsync,
    input  logic       start_btn,
    input  logic       return_title,
    input  logic       title_hit,
    input  logic       prompt_hit,
    output logic [3:0] color_idx,
    output logic       start_game,
    output logic       screen_active
);

    localparam int MAX_FRAMES = (BLINK_FRAMES > FLASH_FRAMES) ? BLINK_FRAMES : FLASH_FRAMES;
    localparam int FC_W       = $clog2(MAX_FRAMES + 1);
    localparam int TC_W       = $clog2(FLASH_TOGGLES + 1);

    localparam logic [FC_W-1:0] BLINK_LAST = FC_W'(BLINK_FRAMES - 1);
    localparam logic [FC_W-1:0] FLASH_LAST = FC_W'(FLASH_FRAMES - 1);
    localparam logic [TC_W-1:0] TOG_LAST   = TC_W'(FLASH_TOGGLES - 1);

    typedef enum logic [1:0] {
        ATTRACT = 2'd0,
        FLASH   = 2'd1,
        LAUNCH  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state;
    logic [FC_W-1:0] frame_cnt;
    logic [TC_W-1:0] tog_cnt;
    logic            text_on;
    logic            vsync_q;
    logic            start_q;
    logic            frame_pulse;
    logic            start_press;

    // Rising edges of vsync and the start button; both last a single cycle.
    assign frame_pulse = vsync & ~vsync_q;
    assign start_press = start_btn & ~start_q;

    // Palette index for one pixel, given the sequencer state and the sprite hits.
    function automatic logic [3:0] pick_color(input state_t st, input logic txt,
                                              input logic title, input logic prompt);
        logic [3:0] c;
        c = IDX_BG;
        case (st)
            ATTRACT: begin
                if (title)       c = IDX_TEXT;
                else if (prompt) c = txt ? IDX_HILITE : IDX_BG;
            end
            FLASH: begin
                if (title)       c = txt ? IDX_HILITE : IDX_TEXT;
                else if (prompt) c = txt ? IDX_HILITE : IDX_BG;
            end
            default: c = IDX_BG;
        endcase
        return c;
    endfunction

    // Edge-detect history; reset loads the live level so a held input is not an edge.
    always_ff @(posedge Clk) begin
        vsync_q <= vsync;
        start_q <= start_btn;
    end

    // Sequencer FSM: blink/flash counters, launch pulse and screen ownership.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= ATTRACT;
            frame_cnt     <= '0;
            tog_cnt       <= '0;
            text_on       <= 1'b1;
            start_game    <= 1'b0;
            screen_active <= 1'b1;
        end else begin
            start_game <= 1'b0;
            case (state)
                ATTRACT: begin
                    // A start press in the same cycle as a frame edge wins; the edge is dropped.
                    if (start_press) begin
                        state     <= FLASH;
                        frame_cnt <= '0;
                        tog_cnt   <= '0;
                        text_on   <= 1'b1;
                    end else if (frame_pulse) begin
                        if (frame_cnt == BLINK_LAST) begin
                            frame_cnt <= '0;
                            text_on   <= ~text_on;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                FLASH: begin
                    if (frame_pulse) begin
                        if (frame_cnt == FLASH_LAST) begin
                            frame_cnt <= '0;
                            text_on   <= ~text_on;
                            tog_cnt   <= tog_cnt + 1'b1;
                            if (tog_cnt == TOG_LAST) begin
                                state      <= LAUNCH;
                                start_game <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    state         <= DONE;
                    screen_active <= 1'b0;
                end
                DONE: begin
                    if (return_title) begin
                        state         <= ATTRACT;
                        frame_cnt     <= '0;
                        tog_cnt       <= '0;
                        text_on       <= 1'b1;
                        screen_active <= 1'b1;
                    end
                end
                default: begin
                    state <= ATTRACT;
                end
            endcase
        end
    end

    // Registered pixel path: one cycle of latency from hit inputs to palette index.
    always_ff @(posedge Clk) begin
        if (Reset) color_idx <= IDX_BG;
        else       color_idx <= pick_color(state, text_on, title_hit, prompt_hit);
    end

endmodule

// File: tb/tb_start_screen_sequencer.sv
// Scoreboard bench for start_screen_sequencer (BLINK_FRAMES=2, FLASH_FRAMES=1,
// FLASH_TOGGLES=3). Directed steps push the hand-computed outputs expected one
// cycle later; a monitor on the falling edge pops and compares them.
module tb_start_screen_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b1;
    logic       start_btn = 1'b1;
    logic       return_title = 1'b0;
    logic       title_hit = 1'b0;
    logic       prompt_hit = 1'b0;
    logic [3:0] color_idx;
    logic       start_game;
    logic       screen_active;

    typedef struct {
        int         cyc;
        logic [3:0] color;
        logic       sg;
        logic       sa;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   sg_seen = 0;
    logic done = 1'b0;

    start_screen_sequencer #(
        .BLINK_FRAMES (2),
        .FLASH_FRAMES (1),
        .FLASH_TOGGLES(3),
        .IDX_BG       (4'h0),
        .IDX_HILITE   (4'h1),
        .IDX_TEXT     (4'h2)
    ) dut (
        .Clk          (clk),
        .Reset        (rst),
        .vsync        (vsync),
        .start_btn    (start_btn),
        .return_title (return_title),
        .title_hit    (title_hit),
        .prompt_hit   (prompt_hit),
        .color_idx    (color_idx),
        .start_game   (start_game),
        .screen_active(screen_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs and record the outputs expected on the next cycle.
    task automatic step(input logic r, input logic vs, input logic btn, input logic ret,
                        input logic title, input logic prompt,
                        input logic [3:0] ecolor, input logic esg, input logic esa,
                        input string name);
        exp_t e;
        rst          = r;
        vsync        = vs;
        start_btn    = btn;
        return_title = ret;
        title_hit    = title;
        prompt_hit   = prompt;
        e.cyc   = cyc + 1;
        e.color = ecolor;
        e.sg    = esg;
        e.sa    = esa;
        e.name  = name;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare outputs against the scoreboard entry due this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (start_game === 1'b1) sg_seen = sg_seen + 1;
        if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks = checks + 1;
            if (e.cyc != cyc) begin
                errors = errors + 1;
                $display("FAIL %s entry due cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            end else if (color_idx !== e.color || start_game !== e.sg || screen_active !== e.sa) begin
                errors = errors + 1;
                $display("FAIL %s color_idx=%0d want %0d start_game=%b want %b screen_active=%b want %b",
                         e.name, color_idx, e.color, start_game, e.sg, screen_active, e.sa);
            end
        end
        if (done) begin
            checks = checks + 1;
            if (q.size() != 0) begin
                errors = errors + 1;
                $display("FAIL drain %0d entries left want 0", q.size());
            end
            checks = checks + 1;
            if (sg_seen != 1) begin
                errors = errors + 1;
                $display("FAIL sg_total start_game cycles=%0d want 1", sg_seen);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout stimulus did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset with vsync and start already high.
        //    r  vs btn ret ti pr  color sg sa
        step(1, 1, 1, 0, 0, 0, 4'd0, 0, 1, "rst_a");
        step(1, 1, 1, 0, 0, 0, 4'd0, 0, 1, "rst_b");
        // T1: held inputs are not edges; title in ATTRACT gives IDX_TEXT (FLASH would give 1).
        step(0, 1, 1, 0, 1, 0, 4'd2, 0, 1, "t1_no_press");
        step(0, 0, 0, 0, 0, 1, 4'd1, 0, 1, "t2_start");
        // T2: four frame edges, prompt steady: 1,1,0,0,1.
        step(0, 1, 0, 0, 0, 1, 4'd1, 0, 1, "t2_e1_edge");
        step(0, 0, 0, 0, 0, 1, 4'd1, 0, 1, "t2_e1");
        step(0, 1, 0, 0, 0, 1, 4'd1, 0, 1, "t2_e2_edge");
        step(0, 0, 0, 0, 0, 1, 4'd0, 0, 1, "t2_e2");
        step(0, 1, 0, 0, 0, 1, 4'd0, 0, 1, "t2_e3_edge");
        step(0, 0, 0, 0, 0, 1, 4'd0, 0, 1, "t2_e3");
        step(0, 1, 0, 0, 0, 1, 4'd0, 0, 1, "t2_e4_edge");
        step(0, 0, 0, 0, 0, 1, 4'd1, 0, 1, "t2_e4");
        // T3: title beats prompt.
        step(0, 0, 0, 0, 1, 1, 4'd2, 0, 1, "t3_priority");
        // Advance frame_cnt to 1 so a non-dropped edge would matter.
        step(0, 1, 0, 0, 0, 1, 4'd1, 0, 1, "t4_pre_edge");
        step(0, 0, 0, 0, 0, 1, 4'd1, 0, 1, "t4_pre");
        // T4: start press together with a frame edge.
        step(0, 1, 1, 0, 1, 0, 4'd2, 0, 1, "t4_press");
        step(0, 0, 1, 0, 1, 0, 4'd1, 0, 1, "t4_flash");
        step(0, 0, 0, 0, 1, 0, 4'd1, 0, 1, "t4_btn_rel");
        step(0, 0, 1, 0, 1, 0, 4'd1, 0, 1, "t4_press_ign");
        // T5: every edge toggles (frame_cnt started at 0); third toggle launches.
        step(0, 1, 0, 0, 1, 0, 4'd1, 0, 1, "t5_tog1_edge");
        step(0, 0, 0, 0, 1, 0, 4'd2, 0, 1, "t5_tog1");
        step(0, 1, 0, 0, 1, 0, 4'd2, 0, 1, "t5_tog2_edge");
        step(0, 0, 0, 0, 1, 0, 4'd1, 0, 1, "t5_tog2");
        step(0, 1, 0, 0, 1, 0, 4'd1, 1, 1, "t5_launch");
        step(0, 0, 0, 0, 1, 0, 4'd0, 0, 0, "t5_done");
        // T6: DONE ignores start presses and frame edges.
        step(0, 0, 1, 0, 1, 1, 4'd0, 0, 0, "t6_btn_a");
        step(0, 1, 0, 0, 1, 1, 4'd0, 0, 0, "t6_edge");
        step(0, 0, 1, 0, 1, 1, 4'd0, 0, 0, "t6_btn_b");
        step(0, 0, 0, 0, 1, 1, 4'd0, 0, 0, "t6_idle");
        step(0, 0, 0, 1, 1, 0, 4'd0, 0, 1, "t6_return");
        step(0, 0, 0, 0, 1, 0, 4'd2, 0, 1, "t6_attract");
        step(0, 0, 0, 0, 0, 1, 4'd1, 0, 1, "t6_text_on");
        step(0, 1, 0, 0, 0, 1, 4'd1, 0, 1, "t6_cnt_edge");
        step(0, 0, 0, 0, 0, 1, 4'd1, 0, 1, "t6_cnt_clr");
        step(0, 0, 0, 1, 0, 1, 4'd1, 0, 1, "t6_ret_ign");
        step(0, 0, 1, 0, 0, 1, 4'd1, 0, 1, "t6_press2");
        step(0, 1, 1, 0, 0, 1, 4'd1, 0, 1, "t6_fl_edge");
        step(0, 0, 1, 0, 0, 1, 4'd0, 0, 1, "t6_fl_tog");
        // Reset in the middle of FLASH.
        step(1, 0, 1, 0, 0, 1, 4'd0, 0, 1, "t6_rst");
        step(0, 0, 1, 0, 1, 0, 4'd2, 0, 1, "t6_rst_attract");
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 0, 1, 0, 4'd2, 0, 1, "t6_post_edge");
            step(0, 0, 1, 0, 1, 0, 4'd2, 0, 1, "t6_post");
        end
        done = 1'b1;
    end

endmodule
